// File: rtl/cla_pkg.sv
// cla_pkg: shared nibble width, FSM encoding and signed-overflow helper
package cla_pkg;
  localparam int NIBBLE_W = 4;
  typedef enum logic [1:0] {IDLE = 2'd0, RUN = 2'd1, DONE = 2'd2} state_t;
  function automatic logic ovf_of(input logic a_msb, input logic b_msb, input logic s_msb);
    return (a_msb == b_msb) && (s_msb != a_msb);
  endfunction
endpackage

// File: rtl/cla_4bit.sv
// cla_4bit: combinational 4-bit carry-lookahead adder slice
module cla_4bit import cla_pkg::*; (
  input  logic [NIBBLE_W-1:0] a,
  input  logic [NIBBLE_W-1:0] b,
  input  logic                cin,
  output logic [NIBBLE_W-1:0] s,
  output logic                cout
);
  logic [NIBBLE_W-1:0] g, p;
  logic [NIBBLE_W:0] c;
  assign g = a & b;
  assign p = a ^ b;
  assign c[0] = cin;
  assign c[1] = g[0] | (p[0] & cin);
  assign c[2] = g[1] | (p[1] & g[0]) | (p[1] & p[0] & cin);
  assign c[3] = g[2] | (p[2] & g[1]) | (p[2] & p[1] & g[0]) | (p[2] & p[1] & p[0] & cin);
  assign c[4] = g[3] | (p[3] & g[2]) | (p[3] & p[2] & g[1]) | (p[3] & p[2] & p[1] & g[0])
              | (p[3] & p[2] & p[1] & p[0] & cin);
  assign s = p ^ c[NIBBLE_W-1:0];
  assign cout = c[NIBBLE_W];
endmodule

// File: rtl/cla_nibble_serial_adder.sv
// cla_nibble_serial_adder: WIDTH-bit adder reusing one cla_4bit slice, one nibble per cycle
module cla_nibble_serial_adder import cla_pkg::*; #(
  parameter int WIDTH = 16
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic             cin,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] sum,
  output logic             cout,
  output logic             ovf
);
  localparam int NIBBLES = WIDTH / NIBBLE_W;
  localparam int IW = NIBBLES > 1 ? $clog2(NIBBLES) : 1;
  localparam logic [IW-1:0] LAST = IW'(NIBBLES - 1);
  if (WIDTH % NIBBLE_W != 0 || WIDTH < 8) begin : g_width_chk
    $error("cla_nibble_serial_adder: WIDTH must be a multiple of 4 and >= 8");
  end
  state_t state;
  logic [IW-1:0] idx;
  logic [WIDTH-1:0] a_q, b_q;
  logic carry;
  logic [NIBBLE_W-1:0] ss;
  logic sc;
  cla_4bit u_slice (
    .a    (a_q[{idx, 2'b00} +: NIBBLE_W]),
    .b    (b_q[{idx, 2'b00} +: NIBBLE_W]),
    .cin  (carry),
    .s    (ss),
    .cout (sc)
  );
  assign in_ready = (state == IDLE);
  always_ff @(posedge clk) begin
    if (rst) begin
      state <= IDLE;
      idx <= '0;
      carry <= 1'b0;
      a_q <= '0;
      b_q <= '0;
      sum <= '0;
      cout <= 1'b0;
      ovf <= 1'b0;
      out_valid <= 1'b0;
    end else begin
      unique case (state)
        IDLE: if (in_valid) begin
          a_q <= a;
          b_q <= b;
          carry <= cin;
          idx <= '0;
          sum <= '0;
          state <= RUN;
        end
        RUN: begin
          sum[{idx, 2'b00} +: NIBBLE_W] <= ss;
          carry <= sc;
          idx <= idx == LAST ? '0 : idx + 1'b1;
          if (idx == LAST) begin
            cout <= sc;
            ovf <= ovf_of(a_q[WIDTH-1], b_q[WIDTH-1], ss[NIBBLE_W-1]);
            out_valid <= 1'b1;
            state <= DONE;
          end
        end
        DONE: if (out_ready) begin
          out_valid <= 1'b0;
          state <= IDLE;
        end
        default: state <= IDLE;
      endcase
    end
  end
endmodule

// File: tb/tb_cla_nibble_serial_adder.sv
// tb_cla_nibble_serial_adder: directed vector table, multi-cycle corner sequences and random ops
module tb_cla_nibble_serial_adder;
  logic clk = 1'b0, rst = 1'b1;
  logic in_valid = 1'b0, in_ready, cin = 1'b0, out_valid, out_ready = 1'b0, cout, ovf;
  logic [15:0] a = '0, b = '0, sum;
  int checks = 0, fails = 0;
  typedef struct {
    logic [15:0] a, b;
    logic cin;
    logic [15:0] s;
    logic co, ov;
  } vec_t;
  vec_t vecs[8];
  cla_nibble_serial_adder #(.WIDTH(16)) dut (
    .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready), .a(a), .b(b), .cin(cin),
    .out_valid(out_valid), .out_ready(out_ready), .sum(sum), .cout(cout), .ovf(ovf)
  );
  always #5 clk = ~clk;
  task automatic check(input string nm, input logic [63:0] got, input logic [63:0] exp);
    checks++;
    if (got !== exp) begin
      fails++;
      $display("FAIL %s: got %h expected %h", nm, got, exp);
    end
  endtask
  task automatic issue(input logic [15:0] ta, input logic [15:0] tb, input logic tc);
    int n = 0;
    @(negedge clk);
    while (!in_ready && n < 50) begin
      @(negedge clk);
      n++;
    end
    if (!in_ready) check("in_ready_timeout", 0, 1);
    a = ta;
    b = tb;
    cin = tc;
    in_valid = 1'b1;
    @(posedge clk);
    #1;
    in_valid = 1'b0;
    a = 16'($urandom);
    b = 16'($urandom);
    cin = 1'($urandom);
  endtask
  task automatic wait_done(output int lat);
    lat = 0;
    while (!out_valid && lat < 50) begin
      @(posedge clk);
      #1;
      lat++;
    end
  endtask
  task automatic consume();
    out_ready = 1'b1;
    @(posedge clk);
    #1;
    out_ready = 1'b0;
  endtask
  initial begin
    int lat;
    logic [16:0] ref_s;
    logic [15:0] ra, rb, held;
    logic rc;
    vecs[0] = '{16'hFFFF, 16'h0001, 1'b0, 16'h0000, 1'b1, 1'b0};
    vecs[1] = '{16'h1234, 16'h4321, 1'b1, 16'h5556, 1'b0, 1'b0};
    vecs[2] = '{16'h7FFF, 16'h0001, 1'b0, 16'h8000, 1'b0, 1'b1};
    vecs[3] = '{16'h8000, 16'h8000, 1'b0, 16'h0000, 1'b1, 1'b1};
    vecs[4] = '{16'h00FF, 16'h0001, 1'b0, 16'h0100, 1'b0, 1'b0};
    vecs[5] = '{16'hFFFF, 16'hFFFF, 1'b1, 16'hFFFF, 1'b1, 1'b0};
    vecs[6] = '{16'h8000, 16'hFFFF, 1'b0, 16'h7FFF, 1'b1, 1'b1};
    vecs[7] = '{16'h0F0F, 16'hF0F0, 1'b1, 16'h0000, 1'b1, 1'b0};
    repeat (2) @(posedge clk);
    #1;
    rst = 1'b0;
    check("reset_state", {in_ready, out_valid, cout, ovf, sum}, {1'b1, 1'b0, 1'b0, 1'b0, 16'h0000});
    foreach (vecs[i]) begin
      issue(vecs[i].a, vecs[i].b, vecs[i].cin);
      wait_done(lat);
      check($sformatf("latency_v%0d", i), lat, 4);
      check($sformatf("result_v%0d", i), {in_ready, cout, ovf, sum}, {1'b0, vecs[i].co, vecs[i].ov, vecs[i].s});
      consume();
      check($sformatf("idle_after_v%0d", i), {in_ready, out_valid}, 2'b10);
    end
    issue(16'h1234, 16'h4321, 1'b1);
    wait_done(lat);
    for (int k = 0; k < 10; k++) begin
      check("backpressure_hold", {out_valid, in_ready, cout, ovf, sum}, {1'b1, 1'b0, 1'b0, 1'b0, 16'h5556});
      @(posedge clk);
      #1;
    end
    consume();
    check("release_in_ready", {in_ready, out_valid}, 2'b10);
    out_ready = 1'b1;
    issue(16'hFFFF, 16'h0001, 1'b0);
    repeat (2) begin
      @(posedge clk);
      #1;
    end
    check("run_ignores_out_ready", {out_valid, in_ready}, 2'b00);
    out_ready = 1'b0;
    rst = 1'b1;
    @(posedge clk);
    #1;
    rst = 1'b0;
    check("abort_reset", {out_valid, in_ready, sum}, {1'b0, 1'b1, 16'h0000});
    repeat (6) begin
      @(posedge clk);
      #1;
    end
    check("abort_no_output", {out_valid, in_ready}, 2'b01);
    issue(16'h00FF, 16'h0001, 1'b0);
    wait_done(lat);
    check("after_abort", {lat[3:0], cout, ovf, sum}, {4'd4, 1'b0, 1'b0, 16'h0100});
    consume();
    for (int n = 0; n < 300; n++) begin
      ra = 16'($urandom);
      rb = 16'($urandom);
      rc = 1'($urandom);
      if (n % 5 == 0) rb = 16'hFFFF - ra;
      ref_s = {1'b0, ra} + {1'b0, rb} + {16'h0000, rc};
      issue(ra, rb, rc);
      wait_done(lat);
      held = sum;
      repeat ($urandom_range(0, 3)) begin
        @(posedge clk);
        #1;
      end
      check($sformatf("random_%0d", n), {lat[3:0], cout, ovf, sum, held},
            {4'd4, ref_s[16], (ra[15] == rb[15]) && (ref_s[15] != ra[15]), ref_s[15:0], ref_s[15:0]});
      consume();
    end
    $display("End of test - %0d assertions evaluated, %0d failures", checks, fails);
    $finish;
  end
endmodule
